// File: rtl/conv1d_ring_loader.sv
// conv1d_ring_loader
//   Feeds the conv1d MAC engine's KERNEL_LENGTH-row input ring from a packed
//   int8 activation stream (4 channels per word), inserting SAME-padding rows
//   at both ends, and presents one window (ring head + valid) per output position.
//   Optional build macro: RING_LOADER_PAD_OFFSET_EN -- pad byte becomes
//   -cfg_input_offset so padded taps contribute zero in the MAC.
module conv1d_ring_loader #(
    parameter int unsigned KERNEL_LENGTH = 8,
    parameter int unsigned PADDING       = 4,
    parameter int unsigned MAX_DEPTH     = 128,
    parameter int unsigned ADDR_W        = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [7:0]                       cfg_depth,
    input  logic [15:0]                      cfg_width,
    input  logic [31:0]                      cfg_input_offset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_data,
    output logic                             wr_en,
    output logic [ADDR_W-1:0]                wr_addr,
    output logic [7:0]                       wr_data,
    output logic [$clog2(KERNEL_LENGTH)-1:0] start_x,
    output logic                             window_valid,
    input  logic                             window_consumed,
    output logic                             busy
);
    localparam int unsigned SLOT_W    = $clog2(KERNEL_LENGTH);
    localparam int unsigned CH_W      = $clog2(MAX_DEPTH);
    localparam int unsigned LOOKAHEAD = KERNEL_LENGTH - PADDING - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PAD_L, S_FILL, S_WIN, S_ADVANCE, S_DONE
    } state_t;

    state_t            state;
    logic [7:0]        depth_r;
    logic [15:0]       width_r;
    logic [7:0]        pad_byte;
    logic [7:0]        pad_value;
    logic [SLOT_W-1:0] head;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] row;
    logic [CH_W-1:0]   ch;
    logic [15:0]       x;
    logic [16:0]       pos;
    logic [31:0]       hold_data;
    logic              hold_valid;

    logic              writing;
    logic              stream_row;
    logic              last_ch;
    logic              accept;
    logic              byte_ok;
    logic [1:0]        lane;
    logic [31:0]       src_word;
    logic [7:0]        cur_byte;
    logic [ADDR_W-1:0] addr_next;
    logic [15:0]       x_next;

`ifdef RING_LOADER_PAD_OFFSET_EN
    assign pad_value = 8'(-cfg_input_offset);
`else
    logic cfg_offset_unused;
    assign pad_value         = 8'h00;
    assign cfg_offset_unused = ^cfg_input_offset;
`endif

    assign start_x = head;

    // Datapath decode: which byte goes out this cycle and whether a word is taken
    always_comb begin
        writing    = (state == S_PAD_L) || (state == S_FILL) || (state == S_ADVANCE);
        stream_row = ((state == S_FILL) || (state == S_ADVANCE)) && (pos < {1'b0, width_r});
        lane       = ch[1:0];
        last_ch    = (ch == CH_W'(depth_r - 8'd1));
        // A new word is taken only when the holding register is empty or its last
        // byte leaves this cycle, and never across a row boundary, so no word of a
        // later position is fetched early and nothing beyond the sequence is taken.
        in_ready   = stream_row && !rst && !start &&
                     (!hold_valid || (lane == 2'd3 && !last_ch));
        accept     = in_valid && in_ready;
        byte_ok    = writing && (!stream_row || hold_valid || in_valid);
        src_word   = hold_valid ? hold_data : in_data;
        cur_byte   = pad_byte;
        if (stream_row) begin
            case (lane)
                2'd0:    cur_byte = src_word[7:0];
                2'd1:    cur_byte = src_word[15:8];
                2'd2:    cur_byte = src_word[23:16];
                default: cur_byte = src_word[31:24];
            endcase
        end
        addr_next  = ADDR_W'(slot) * ADDR_W'(depth_r) + ADDR_W'(ch);
        x_next     = x + 16'd1;
    end

    // Sequencer: pad/fill rows, window handshake, per-window row replacement
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            window_valid <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            depth_r      <= '0;
            width_r      <= '0;
            pad_byte     <= '0;
            head         <= '0;
            slot         <= '0;
            row          <= '0;
            ch           <= '0;
            x            <= '0;
            pos          <= '0;
            hold_data    <= '0;
            hold_valid   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                depth_r      <= cfg_depth;
                width_r      <= cfg_width;
                pad_byte     <= pad_value;
                head         <= '0;
                slot         <= '0;
                row          <= '0;
                ch           <= '0;
                x            <= '0;
                pos          <= '0;
                hold_valid   <= 1'b0;
                window_valid <= 1'b0;
                busy         <= 1'b1;
                state        <= S_PAD_L;
            end else begin
                case (state)
                    S_PAD_L, S_FILL, S_ADVANCE: begin
                        if (byte_ok) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr_next;
                            wr_data <= cur_byte;
                            if (accept) begin
                                hold_data  <= in_data;
                                hold_valid <= 1'b1;
                            end else if (stream_row && lane == 2'd3) begin
                                hold_valid <= 1'b0;
                            end
                            if (!last_ch) begin
                                ch <= ch + 1'b1;
                            end else begin
                                ch   <= '0;
                                row  <= row + 1'b1;
                                slot <= slot + 1'b1;
                                pos  <= pos + 17'd1;
                                if (state == S_PAD_L && row == SLOT_W'(PADDING - 1)) begin
                                    state <= S_FILL;
                                    row   <= '0;
                                    pos   <= '0;
                                end else if (state == S_FILL && row == SLOT_W'(LOOKAHEAD)) begin
                                    state        <= S_WIN;
                                    window_valid <= 1'b1;
                                end else if (state == S_ADVANCE) begin
                                    head         <= head + 1'b1;
                                    state        <= S_WIN;
                                    window_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    S_WIN: begin
                        if (window_consumed) begin
                            window_valid <= 1'b0;
                            x            <= x_next;
                            if (x_next == width_r) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_ADVANCE;
                                slot  <= head;
                                pos   <= {1'b0, x_next} + 17'(LOOKAHEAD);
                            end
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_conv1d_ring_loader.sv
// tb_conv1d_ring_loader
//   Random-stimulus scoreboard bench for conv1d_ring_loader. Expected ring writes
//   are derived from positions/padding and pushed when a sequence is issued; a
//   monitor pops them on every wr_en. Windows are checked against a ring image.
module tb_conv1d_ring_loader;
    localparam int K  = 8;
    localparam int P  = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    cfg_depth;
    logic [15:0]   cfg_width;
    logic [31:0]   cfg_input_offset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [2:0]    start_x;
    logic          window_valid;
    logic          window_consumed;
    logic          busy;

    always #5 clk = ~clk;

    conv1d_ring_loader #(
        .KERNEL_LENGTH(K),
        .PADDING(P),
        .MAX_DEPTH(128),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_depth(cfg_depth),
        .cfg_width(cfg_width),
        .cfg_input_offset(cfg_input_offset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start_x(start_x),
        .window_valid(window_valid),
        .window_consumed(window_consumed),
        .busy(busy)
    );

    int          tests = 0;
    int          fails = 0;
    logic [17:0] exp_wr[$];
    logic [31:0] words_q[$];
    logic [31:0] gen_words[];
    logic [7:0]  ring_m[0:1023];
    logic [17:0] e_wr;
    bit          drv_en = 1'b0;
    bit          toggle = 1'b0;
    int          drv_mode = 0;
    int          acc_cnt = 0;
    int          wr_seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every ring write must be the next expected (addr, byte)
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            wr_seen++;
            ring_m[wr_addr] = wr_data;
            if (exp_wr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_unexpected actual addr=%0d data=%02h required=no write", wr_addr, wr_data);
            end else begin
                e_wr = exp_wr.pop_front();
                chk("wr_addr", wr_addr, e_wr[17:8]);
                chk("wr_data", wr_data, e_wr[7:0]);
            end
        end
    end

    // Stream source: offers queued words per mode, counts accepted handshakes
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            toggle = ~toggle;
            if (drv_en && words_q.size() > 0) begin
                case (drv_mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = toggle;
                    default: in_valid = ($urandom_range(0, 2) != 0);
                endcase
            end else begin
                in_valid = 1'b0;
            end
            in_data = in_valid ? words_q[0] : $urandom;
            #4;
            if (in_valid && in_ready) begin
                words_q.delete(0);
                acc_cnt++;
            end
        end
    end

    function automatic logic [7:0] stream_byte(input int d, input int pos, input int ch);
        int          idx = pos * d + ch;
        logic [31:0] w   = gen_words[idx / 4];
        return w[8 * (idx % 4) +: 8];
    endfunction

    function automatic logic [7:0] exp_byte(input int d, input int w, input int pos,
                                            input int ch, input logic [7:0] pad);
        if (pos < 0 || pos >= w) return pad;
        return stream_byte(d, pos, ch);
    endfunction

    task automatic push_row(input int d, input int w, input int slot, input int pos,
                            input logic [7:0] pad);
        for (int ch = 0; ch < d; ch++)
            exp_wr.push_back({10'(slot * d + ch), exp_byte(d, w, pos, ch, pad)});
    endtask

    task automatic make_words(input int n);
        gen_words = new[n];
        foreach (gen_words[i]) gen_words[i] = $urandom;
    endtask

    task automatic run_seq(input int d, input int w, input logic [31:0] off, input int mode,
                           input bit fill_consume, input int abort_after);
        int         nwords = w * d / 4;
        logic [7:0] pad;
        bit         ok;
        int         base;
        int         bad;
        int         slot;
`ifdef RING_LOADER_PAD_OFFSET_EN
        pad = 8'(-off);
`else
        pad = 8'h00;
`endif
        exp_wr.delete();
        words_q.delete();
        for (int i = 0; i < nwords; i++) words_q.push_back(gen_words[i]);
        for (int i = 0; i < 3; i++) words_q.push_back($urandom);
        // Initial ring: slot s holds position s-P; then one new row per later window
        for (int s = 0; s < K; s++) push_row(d, w, s, s - P, pad);
        for (int x = 1; x < w; x++) push_row(d, w, (x - 1) % K, x + K - P - 1, pad);
        acc_cnt  = 0;
        drv_mode = mode;
        @(negedge clk);
        cfg_depth        = 8'(d);
        cfg_width        = 16'(w);
        cfg_input_offset = off;
        start            = 1'b1;
        drv_en           = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (fill_consume) begin
            repeat (4 * d + 2) @(negedge clk);
            window_consumed = 1'b1;
            @(negedge clk);
            window_consumed = 1'b0;
        end
        for (int x = 0; x < w; x++) begin
            ok = 1'b0;
            for (int t = 0; t < 4000 && !ok; t++) begin
                @(negedge clk);
                if (window_valid) ok = 1'b1;
            end
            chk("window_seen", ok, 1);
            if (!ok) begin
                drv_en = 1'b0;
                exp_wr.delete();
                words_q.delete();
                return;
            end
            #1;
            chk("start_x", start_x, x % K);
            bad = 0;
            for (int k = 0; k < K; k++) begin
                slot = (x + k) % K;
                for (int ch = 0; ch < d; ch++)
                    if (ring_m[slot * d + ch] !== exp_byte(d, w, x - P + k, ch, pad)) bad++;
            end
            chk("ring_window_bad_bytes", bad, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            window_consumed = 1'b1;
            @(negedge clk);
            window_consumed = 1'b0;
            if (x == abort_after) begin
                base = wr_seen;
                ok   = 1'b0;
                for (int t = 0; t < 200 && !ok; t++) begin
                    @(negedge clk);
                    if (wr_seen >= base + 3) ok = 1'b1;
                end
                chk("advance_progress", ok, 1);
                #2 rst = 1'b1;
                @(negedge clk);
                #1;
                chk("rst_in_ready", in_ready, 0);
                chk("rst_wr_en", wr_en, 0);
                chk("rst_wr_addr", wr_addr, 0);
                chk("rst_wr_data", wr_data, 0);
                chk("rst_start_x", start_x, 0);
                chk("rst_window_valid", window_valid, 0);
                chk("rst_busy", busy, 0);
                rst    = 1'b0;
                drv_en = 1'b0;
                exp_wr.delete();
                words_q.delete();
                return;
            end
        end
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        chk("busy_done", ok, 1);
        chk("no_extra_window", window_valid, 0);
        repeat (4) @(negedge clk);
        chk("words_accepted", acc_cnt, nwords);
        chk("writes_pending", exp_wr.size(), 0);
        drv_en = 1'b0;
        @(negedge clk);
        words_q.delete();
    endtask

    initial begin
        int d;
        int w;
        rst              = 1'b1;
        start            = 1'b0;
        cfg_depth        = '0;
        cfg_width        = '0;
        cfg_input_offset = '0;
        window_consumed  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_start_x", start_x, 0);
        chk("reset_window_valid", window_valid, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;

        gen_words    = new[1];
        gen_words[0] = 32'h04030201;
        run_seq(4, 1, 32'd128, 0, 1'b0, -1);

        make_words(20);
        run_seq(8, 10, 32'd128, 0, 1'b0, -1);
        run_seq(8, 10, 32'h55, 1, 1'b0, -1);
        run_seq(8, 10, 32'hffffff80, 0, 1'b1, -1);

        make_words(20);
        run_seq(8, 10, 32'd7, 2, 1'b0, 2);
        run_seq(8, 10, 32'd7, 2, 1'b0, -1);

        make_words(3 * 128 / 4);
        run_seq(128, 3, 32'd200, 2, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            d = 4 * $urandom_range(1, 6);
            w = $urandom_range(1, 12);
            make_words(w * d / 4);
            run_seq(d, w, $urandom, $urandom_range(0, 2), 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout actual=running required=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end
endmodule
